// File: rtl/dualrail_token_sender.sv
// Dual-rail four-phase token sender.
// Encodes one logical bit per token onto a 0/1 rail pair and waits for the
// even-zeroes stage to answer on its parity rails. It then returns the rails
// to zero and presents the captured parity downstream.
// The parity rails are asynchronous. Only their synchronized copies drive decisions.
module dualrail_token_sender #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_bit,
    output logic        bit0,
    output logic        bit1,
    input  logic        parity0,
    input  logic        parity1,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_parity,
    output logic [15:0] token_count,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        RTZ,
        RESULT,
        ERROR
    } state_t;

    // Wait counter value on the edge where it would reach TIMEOUT
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    state_t      state_reg;
    logic        bit_reg;
    logic        bit0_reg;
    logic        bit1_reg;
    logic        in_ready_reg;
    logic        out_valid_reg;
    logic        out_parity_reg;
    logic [15:0] token_count_reg;
    logic        err_reg;
    logic [15:0] wait_cnt_reg;

    logic [SYNC_STAGES-1:0] p0_sync_reg;
    logic [SYNC_STAGES-1:0] p1_sync_reg;
    logic                   p0s;
    logic                   p1s;

    // Parity synchronizer chains, one flop per stage
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                // First stage samples the raw asynchronous rails
                always_ff @(posedge clk) begin
                    if (rst) begin
                        p0_sync_reg[gi] <= 1'b0;
                        p1_sync_reg[gi] <= 1'b0;
                    end else begin
                        p0_sync_reg[gi] <= parity0;
                        p1_sync_reg[gi] <= parity1;
                    end
                end
            end else begin : g_next
                // Later stages shift the previous stage forward
                always_ff @(posedge clk) begin
                    if (rst) begin
                        p0_sync_reg[gi] <= 1'b0;
                        p1_sync_reg[gi] <= 1'b0;
                    end else begin
                        p0_sync_reg[gi] <= p0_sync_reg[gi-1];
                        p1_sync_reg[gi] <= p1_sync_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign p0s = p0_sync_reg[SYNC_STAGES-1];
    assign p1s = p1_sync_reg[SYNC_STAGES-1];

    // Handshake FSM. The rails are a registered image of the current state,
    // so they lag every state change by one cycle and never both go high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            bit_reg         <= 1'b0;
            bit0_reg        <= 1'b0;
            bit1_reg        <= 1'b0;
            in_ready_reg    <= 1'b1;
            out_valid_reg   <= 1'b0;
            out_parity_reg  <= 1'b0;
            token_count_reg <= 16'd0;
            err_reg         <= 1'b0;
            wait_cnt_reg    <= 16'd0;
        end else begin
            bit1_reg <= (state_reg == DRIVE) &  bit_reg;
            bit0_reg <= (state_reg == DRIVE) & ~bit_reg;

            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        bit_reg      <= in_bit;
                        wait_cnt_reg <= 16'd0;
                        in_ready_reg <= 1'b0;
                        state_reg    <= DRIVE;
                    end
                end

                DRIVE: begin
                    if (p0s && p1s) begin
                        err_reg   <= 1'b1;
                        state_reg <= ERROR;
                    end else if (p0s ^ p1s) begin
                        out_parity_reg <= p1s;
                        wait_cnt_reg   <= 16'd0;
                        state_reg      <= RTZ;
                    end else if (wait_cnt_reg == TIMEOUT_LAST) begin
                        err_reg   <= 1'b1;
                        state_reg <= ERROR;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 16'd1;
                    end
                end

                RTZ: begin
                    if (p0s && p1s) begin
                        err_reg   <= 1'b1;
                        state_reg <= ERROR;
                    end else if (!p0s && !p1s) begin
                        // Counter wraps silently at 16 bits
                        token_count_reg <= token_count_reg + 16'd1;
                        out_valid_reg   <= 1'b1;
                        state_reg       <= RESULT;
                    end else if (wait_cnt_reg == TIMEOUT_LAST) begin
                        err_reg   <= 1'b1;
                        state_reg <= ERROR;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 16'd1;
                    end
                end

                RESULT: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end

                ERROR: begin
                    // Terminal until reset
                    in_ready_reg  <= 1'b0;
                    out_valid_reg <= 1'b0;
                end

                default: begin
                    err_reg       <= 1'b1;
                    in_ready_reg  <= 1'b0;
                    out_valid_reg <= 1'b0;
                    state_reg     <= ERROR;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_reg;
    assign bit0        = bit0_reg;
    assign bit1        = bit1_reg;
    assign out_valid   = out_valid_reg;
    assign out_parity  = out_parity_reg;
    assign token_count = token_count_reg;
    assign err         = err_reg;

endmodule

// File: tb/tb_dualrail_token_sender.sv
// Directed bench for dualrail_token_sender with a behavioural responder.
// The responder can act as the even-zeroes stage, an always-parity1 echo,
// a silent stage, or a stage that drives both parity rails high.
module tb_dualrail_token_sender;

    localparam int SYNC = 2;
    localparam int TMO  = 8;
    localparam int LAT  = 2 * SYNC + 4;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_bit;
    logic        bit0;
    logic        bit1;
    logic        parity0;
    logic        parity1;
    logic        out_valid;
    logic        out_ready;
    logic        out_parity;
    logic [15:0] token_count;
    logic        err;

    // Responder modes: 0 even-zeroes, 1 echo parity1, 2 silent, 3 both high
    logic [1:0] mode;
    logic       even;
    logic       pend_valid;
    logic       pend_zero;

    int n_checks;
    int n_errs;

    dualrail_token_sender #(
        .SYNC_STAGES(SYNC),
        .TIMEOUT    (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_bit     (in_bit),
        .bit0       (bit0),
        .bit1       (bit1),
        .parity0    (parity0),
        .parity1    (parity1),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_parity (out_parity),
        .token_count(token_count),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Zero-delay responder
    assign parity1 = (mode == 2'd0) ? ((bit1 & even) | (bit0 & ~even)) :
                     (mode == 2'd1) ? (bit0 | bit1) :
                     (mode == 2'd3);
    assign parity0 = (mode == 2'd0) ? ((bit1 & ~even) | (bit0 & even)) :
                     (mode == 2'd3);

    // Even-zeroes stage state commits once the rails return to zero
    always @(posedge clk) begin
        if (rst) begin
            even       <= 1'b1;
            pend_valid <= 1'b0;
            pend_zero  <= 1'b0;
        end else if (bit0 || bit1) begin
            pend_valid <= 1'b1;
            pend_zero  <= bit0;
        end else if (pend_valid) begin
            pend_valid <= 1'b0;
            if (pend_zero) even <= ~even;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Offer one bit and follow it to RESULT; leaves the result unacknowledged
    task automatic send_token(input string tag, input logic b, input logic exp_par,
                              input logic [15:0] exp_cnt);
        int   cyc;
        logic saw0;
        logic saw1;
        logic both;
        chk({tag, "_in_ready_idle"}, in_ready, 1);
        in_valid = 1'b1;
        in_bit   = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, "_in_ready_busy"}, in_ready, 0);
        cyc  = 0;
        saw0 = 1'b0;
        saw1 = 1'b0;
        both = 1'b0;
        while (!out_valid && cyc < 64) begin
            @(posedge clk); #1;
            cyc++;
            saw0 |= bit0;
            saw1 |= bit1;
            both |= bit0 & bit1;
        end
        chk({tag, "_latency"}, cyc, LAT);
        chk({tag, "_rails_seen"}, {saw1, saw0, both}, b ? 3'b100 : 3'b010);
        chk({tag, "_rails_rtz"}, {bit1, bit0}, 2'b00);
        chk({tag, "_out_parity"}, out_parity, exp_par);
        chk({tag, "_token_count"}, token_count, exp_cnt);
        $display("token %s bit=%0d parity=%0d count=%0d latency=%0d",
                 tag, b, out_parity, token_count, cyc);
    endtask

    task automatic ack(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_ack_out_valid"}, out_valid, 0);
        chk({tag, "_ack_in_ready"}, in_ready, 1);
    endtask

    logic       seq_bits [4];
    logic       seq_par  [4];
    int         cyc;

    initial begin
        n_checks  = 0;
        n_errs    = 0;
        mode      = 2'd1;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        out_ready = 1'b0;
        seq_bits  = '{1'b0, 1'b1, 1'b0, 1'b0};
        seq_par   = '{1'b0, 1'b0, 1'b1, 1'b0};

        // Reset state
        do_reset();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_rails", {bit1, bit0}, 2'b00);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_parity", out_parity, 0);
        chk("rst_token_count", token_count, 16'd0);
        chk("rst_err", err, 0);
        $display("reset done");

        // Bit 0 against an echo-parity1 responder, then hold the result
        mode = 2'd1;
        send_token("echo0", 1'b0, 1'b1, 16'd1);
        chk("echo0_out_valid", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("hold_out_valid", out_valid, 1);
            chk("hold_out_parity", out_parity, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_rails", {bit1, bit0}, 2'b00);
        end
        $display("hold 10 cycles in result parity=%0d", out_parity);
        ack("echo0");

        // Sequence 0,1,0,0 against the even-zeroes stage
        do_reset();
        mode = 2'd0;
        for (int i = 0; i < 4; i++) begin
            send_token("evz", seq_bits[i], seq_par[i], 16'(i + 1));
            ack("evz");
        end
        chk("evz_total", token_count, 16'd4);

        // Reset in the middle of DRIVE drops the rails and the token
        do_reset();
        mode     = 2'd2;
        in_valid = 1'b1;
        in_bit   = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midrst_rails_before", {bit1, bit0}, 2'b01);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_rails_after", {bit1, bit0}, 2'b00);
        rst = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            @(posedge clk); #1;
        end
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_token_count", token_count, 16'd0);
        chk("midrst_in_ready", in_ready, 1);
        $display("mid-handshake reset count=%0d", token_count);

        // Both parity rails high during DRIVE
        do_reset();
        mode     = 2'd2;
        in_valid = 1'b1;
        in_bit   = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        mode     = 2'd3;
        for (int k = 1; k <= SYNC + 1; k++) begin
            @(posedge clk); #1;
            chk("both_err", err, (k == SYNC + 1) ? 1 : 0);
        end
        $display("both-high error err=%0d", err);
        mode = 2'd1;
        do_reset();
        chk("both_rst_err", err, 0);
        chk("both_rst_in_ready", in_ready, 1);

        // Silent responder times out after TIMEOUT cycles in DRIVE
        mode     = 2'd2;
        in_valid = 1'b1;
        in_bit   = 1'b0;
        @(posedge clk); #1;
        for (int k = 1; k <= TMO; k++) begin
            @(posedge clk); #1;
            chk("tmo_err", err, (k == TMO) ? 1 : 0);
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("tmo_stuck_rails", {bit1, bit0}, 2'b00);
            chk("tmo_stuck_in_ready", in_ready, 0);
            chk("tmo_stuck_out_valid", out_valid, 0);
            chk("tmo_stuck_err", err, 1);
        end
        in_valid = 1'b0;
        $display("timeout error err=%0d", err);
        mode = 2'd1;
        do_reset();
        chk("tmo_rst_err", err, 0);
        chk("tmo_rst_in_ready", in_ready, 1);

        // Run the counter up to 0xFFFF, then one more token wraps it
        mode      = 2'd1;
        in_bit    = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cyc       = 0;
        while (token_count != 16'hFFFF && cyc < 800000) begin
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        chk("wrap_preload_done", (token_count == 16'hFFFF) ? 1 : 0, 1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        chk("wrap_preload_count", token_count, 16'hFFFF);
        $display("preload count=0x%0h cycles=%0d", token_count, cyc);
        send_token("wrap", 1'b1, 1'b1, 16'h0000);
        chk("wrap_err", err, 0);
        ack("wrap");

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/dualrail_token_sender.md
DUALRAIL_TOKEN_SENDER -- requirements
Module: dualrail_token_sender

Interface
REQ-001 Parameter SYNC_STAGES, default 2: flops in each parity synchronizer chain; legal range 2..4.
REQ-002 Parameter TIMEOUT, default 255: maximum cycles spent waiting in DRIVE or RTZ before error; legal range 1..65535.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 in_valid  input  1  upstream offers a data bit.
REQ-006 in_ready  output  1  sender accepts the bit this cycle.
REQ-007 in_bit  input  1  logical bit to encode.
REQ-008 bit0  output  1  dual-rail "0" rail to the even-zeroes stage.
REQ-009 bit1  output  1  dual-rail "1" rail to the even-zeroes stage.
REQ-010 parity0  input  1  asynchronous dual-rail parity "0" rail from the even-zeroes stage.
REQ-011 parity1  input  1  asynchronous dual-rail parity "1" rail from the even-zeroes stage.
REQ-012 out_valid  output  1  captured parity result available.
REQ-013 out_ready  input  1  downstream consumes the result.
REQ-014 out_parity  output  1  captured result; 1 means parity1 answered, 0 means parity0 answered.
REQ-015 token_count  output  16  completed four-phase cycles, mod 2^16.
REQ-016 err  output  1  sticky protocol or timeout error.

Function
REQ-017 parity0 and parity1 SHALL each pass through a SYNC_STAGES-deep flop chain; p0s and p1s denote the chain outputs, and no FSM decision SHALL use the raw inputs.
REQ-018 FSM states SHALL be IDLE, DRIVE, RTZ, RESULT and ERROR.
REQ-019 IDLE: in_ready=1, rails low; on in_valid=1, register in_bit and go to DRIVE next cycle.
REQ-020 DRIVE: bit1=latched bit and bit0=~latched bit, both registered; exactly one rail high.
REQ-021 In DRIVE, if p0s XOR p1s, capture out_parity=p1s and go to RTZ.
REQ-022 In DRIVE or RTZ, p0s=p1s=1 is illegal: set err and go to ERROR.
REQ-023 RTZ: both rails low; when p0s=0 and p1s=0, increment token_count and go to RESULT.
REQ-024 RESULT: out_valid=1 with out_parity stable; on out_ready=1 go to IDLE next cycle.
REQ-025 in_ready SHALL be 0 in every state except IDLE; there is no combinational path from in_valid to in_ready or from out_ready to out_valid.
REQ-026 A wait counter SHALL clear on entry to DRIVE and on entry to RTZ, and SHALL increment each cycle spent in either state.
REQ-027 When the wait counter reaches TIMEOUT, set err and go to ERROR.
REQ-028 ERROR: rails low, in_ready=0, out_valid=0; the block SHALL stay in ERROR until rst.
REQ-029 token_count SHALL wrap from 0xFFFF to 0x0000 with no flag.
REQ-030 Rails SHALL never both be high, and SHALL never change in the same cycle as a state's entry condition is evaluated; they are registered outputs of the FSM state.
REQ-031 Minimum token latency SHALL be 2*SYNC_STAGES+4 cycles from in_valid acceptance to out_valid, given a zero-delay responder.

Reset
REQ-032 While rst=1 at a clock edge: state=IDLE, bit0=bit1=0, out_valid=0, out_parity=0, token_count=0, err=0, wait counter=0, synchronizer flops=0.
REQ-033 After rst, in_ready=1 in the first cycle with rst=0.
REQ-034 rst asserted mid-handshake SHALL drop the rails to 0 in the next cycle and discard the pending token; token_count SHALL not increment.

Verification
REQ-035 Bench SHALL apply in_bit=0 with a responder that echoes parity1 -> bit0=1, bit1=0; then out_parity=1, out_valid=1, token_count=1; rails return to 0 before out_valid.
REQ-036 Bench SHALL send the sequence 0,1,0,0 against the even-zeroes model (initial parity1) -> out_parity sequence 0,0,1,0 and token_count=4.
REQ-037 Bench SHALL hold out_ready=0 for 10 cycles in RESULT -> out_valid and out_parity stay stable, in_ready=0, bit0=bit1=0.
REQ-038 Bench SHALL use a responder that never answers, with TIMEOUT=8 -> err=1 exactly 8 cycles after DRIVE entry, rails=0, FSM stuck in ERROR until rst.
REQ-039 Bench SHALL force parity0=parity1=1 during DRIVE -> err=1 after SYNC_STAGES+1 cycles; then assert rst -> err=0, in_ready=1.
REQ-040 Bench SHALL preload token_count to 0xFFFF through 65535 tokens and complete one more token -> token_count=0x0000, err=0.
